// File: rtl/enc_onehot_hist.sv
// Per-line saturating event histogram behind the 4-to-15 one-hot encoder.
// Multi-hot vectors set a sticky error. Counters are read through a registered single-cycle port.
module enc_onehot_hist #(
  parameter int unsigned N     = 15,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TOT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     oh,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [TOT_W-1:0] tot,
  output logic             err,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [TOT_W-1:0] tot_q, tot_d;
  logic             err_q, err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             oh_any_c, oh_multi_c, sat_c;

  // x & (x-1) clears the lowest set bit, so any remainder means two or more lines are hot
  always_comb begin
    oh_any_c   = |oh;
    oh_multi_c = |(oh & (oh - N'(1)));
  end

  always_comb begin
    cnt_d      = cnt_q;
    tot_d      = tot_q;
    err_d      = err_q;
    rd_valid_d = rd_req;
    rd_data_d  = rd_data_q;

    // Read snapshot uses pre-update counters; out-of-range indices return zero
    if (rd_req) begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < N; i++) begin
        if (rd_idx == IDX_W'(i)) rd_data_d = cnt_q[i];
      end
    end

    if (clr) begin
      for (int unsigned i = 0; i < N; i++) cnt_d[i] = '0;
      tot_d = '0;
      err_d = 1'b0;
    end else if (oh_multi_c) begin
      err_d = 1'b1;
    end else if (oh_any_c) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (oh[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (tot_q != '1) tot_d = tot_q + TOT_W'(1);
    end
  end

  always_comb begin
    sat_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) sat_c = sat_c | (&cnt_q[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      tot_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      tot_q      <= tot_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign tot      = tot_q;
  assign err      = err_q;
  assign sat      = sat_c;

endmodule

// File: tb/tb_enc_onehot_hist.sv
// Scoreboard bench for enc_onehot_hist: randomized and directed traffic against an array-based model.
module tb_enc_onehot_hist;

  localparam int unsigned N     = 15;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned TOT_W = 12;
  localparam int CNT_MAX = 255;
  localparam int TOT_MAX = 4095;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     oh;
  logic             clr;
  logic             rd_req;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic [TOT_W-1:0] tot;
  logic             err;
  logic             sat;

  enc_onehot_hist #(.N(N), .CNT_W(CNT_W), .IDX_W(IDX_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst(rst), .oh(oh), .clr(clr), .rd_req(rd_req), .rd_idx(rd_idx),
    .rd_valid(rd_valid), .rd_data(rd_data), .tot(tot), .err(err), .sat(sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain integer histogram
  int cnt_m [N];
  int tot_m;
  bit err_m;
  bit exp_rv;
  bit mon_en;
  int rd_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_sat();
    for (int i = 0; i < int'(N); i++) if (cnt_m[i] == CNT_MAX) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) cnt_m[i] = 0;
    tot_m  = 0;
    err_m  = 1'b0;
    exp_rv = 1'b0;
    rd_q.delete();
  endtask

  // Drive one cycle of inputs at negedge, then advance the model at the posedge
  task automatic step(input logic [N-1:0] v_oh, input bit v_clr, input bit v_req,
                      input logic [IDX_W-1:0] v_idx);
    int ones;
    @(negedge clk);
    oh = v_oh; clr = v_clr; rd_req = v_req; rd_idx = v_idx;
    @(posedge clk);
    exp_rv = v_req;
    if (v_req) rd_q.push_back((int'(v_idx) < int'(N)) ? cnt_m[v_idx] : 0);
    ones = $countones(v_oh);
    if (v_clr) begin
      for (int i = 0; i < int'(N); i++) cnt_m[i] = 0;
      tot_m = 0;
      err_m = 1'b0;
    end else if (ones >= 2) begin
      err_m = 1'b1;
    end else if (ones == 1) begin
      for (int i = 0; i < int'(N); i++)
        if (v_oh[i] && cnt_m[i] < CNT_MAX) cnt_m[i] = cnt_m[i] + 1;
      if (tot_m < TOT_MAX) tot_m = tot_m + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: per-cycle status against the model, read data popped from the scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      check("rd_valid", 32'(rd_valid), 32'(exp_rv));
      check("tot", 32'(tot), 32'(tot_m));
      check("err", 32'(err), 32'(err_m));
      check("sat", 32'(sat), 32'(model_sat()));
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          check("rd_unexpected", 32'(1), 32'(0));
        end else begin
          check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int r;
    logic [N-1:0] v;
    mon_en = 1'b0;
    rst = 1'b0; oh = '0; clr = 1'b0; rd_req = 1'b0; rd_idx = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_valid", 32'(rd_valid), 32'(0));
    check("rst_rd_data", 32'(rd_data), 32'(0));
    check("rst_tot", 32'(tot), 32'(0));
    check("rst_err_sat", 32'({err, sat}), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // Three events on line 6, then read it
    repeat (3) step(15'h0040, 1'b0, 1'b0, '0);
    step('0, 1'b0, 1'b1, 4'd6);
    #1;
    check("t1_rd_valid", 32'(rd_valid), 32'(1));
    check("t1_rd_data", 32'(rd_data), 32'(3));
    check("t1_tot", 32'(tot), 32'(3));
    check("t1_err", 32'(err), 32'(0));

    // Saturation of line 0 while tot keeps counting
    step('0, 1'b1, 1'b0, '0);
    repeat (260) step(15'h0001, 1'b0, 1'b0, '0);
    step('0, 1'b0, 1'b1, 4'd0);
    #1;
    check("t2_rd_data", 32'(rd_data), 32'(255));
    check("t2_sat", 32'(sat), 32'(1));
    check("t2_tot", 32'(tot), 32'(260));

    // Multi-hot sets sticky err and counts nothing
    step('0, 1'b1, 1'b0, '0);
    step(15'h0003, 1'b0, 1'b0, '0);
    step(15'h4000, 1'b0, 1'b0, '0);
    step('0, 1'b0, 1'b1, 4'd0);
    #1;
    check("t3_cnt0", 32'(rd_data), 32'(0));
    step('0, 1'b0, 1'b1, 4'd1);
    #1;
    check("t3_cnt1", 32'(rd_data), 32'(0));
    step('0, 1'b0, 1'b1, 4'd14);
    #1;
    check("t3_cnt14", 32'(rd_data), 32'(1));
    check("t3_err", 32'(err), 32'(1));
    check("t3_tot", 32'(tot), 32'(1));

    // Read and event on the same line in one cycle
    step('0, 1'b1, 1'b0, '0);
    repeat (5) step(15'h0100, 1'b0, 1'b0, '0);
    step(15'h0100, 1'b0, 1'b1, 4'd8);
    #1;
    check("t4_old", 32'(rd_data), 32'(5));
    step('0, 1'b0, 1'b1, 4'd8);
    #1;
    check("t4_new", 32'(rd_data), 32'(6));

    // clr beats a same-cycle event; out-of-range index reads zero
    step(15'h0002, 1'b0, 1'b0, '0);
    step(15'h0005, 1'b0, 1'b0, '0);
    step(15'h0002, 1'b1, 1'b0, '0);
    step('0, 1'b0, 1'b1, 4'd1);
    #1;
    check("t5_cnt1", 32'(rd_data), 32'(0));
    check("t5_tot", 32'(tot), 32'(0));
    check("t5_err", 32'(err), 32'(0));
    step('0, 1'b0, 1'b1, 4'd15);
    #1;
    check("t5_oob_valid", 32'(rd_valid), 32'(1));
    check("t5_oob_data", 32'(rd_data), 32'(0));
    step('0, 1'b0, 1'b0, '0);
    #1;
    check("t5_hold", 32'(rd_data), 32'(0));

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      v = '0;
      else if (r < 85) v = N'(1) << $urandom_range(0, N - 1);
      else             v = N'($urandom) | (N'(1) << $urandom_range(0, N - 1))
                           | (N'(1) << $urandom_range(0, N - 1)) | N'(3) << $urandom_range(0, N - 2);
      step(v, ($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1,
           IDX_W'($urandom_range(0, 15)));
    end
    idle(2);

    // Async reset between edges during a read
    repeat (20) step(15'h0400, 1'b0, 1'b0, '0);
    step(15'h0003, 1'b0, 1'b1, 4'd10);
    #1;
    check("t6_pre_valid", 32'(rd_valid), 32'(1));
    mon_en = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    check("t6_rd_valid", 32'(rd_valid), 32'(0));
    check("t6_rd_data", 32'(rd_data), 32'(0));
    check("t6_tot", 32'(tot), 32'(0));
    check("t6_err", 32'(err), 32'(0));
    model_reset();
    oh = '0; clr = 1'b0; rd_req = 1'b0; rd_idx = '0;
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (4) step(15'h0010, 1'b0, 1'b0, '0);
    step('0, 1'b0, 1'b1, 4'd4);
    #1;
    check("t6_resume", 32'(rd_data), 32'(4));
    idle(2);

    check("sb_empty", 32'(rd_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
